// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer between decoded core memory controls and a req/gnt data bus.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        misalign_err_o,
    output logic        timeout_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        we_q, signed_q;
    logic [1:0]  size_q, off_q;
    logic        misaligned, accept, tmo;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, rdata_d;
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        misaligned = (req_size_i == 2'b11) | (req_size_i == 2'b01 & req_addr_i[0])
                   | (req_size_i == 2'b10 & |req_addr_i[1:0]);
        accept     = state_q == IDLE & req_valid_i & !misaligned;
        tmo        = cnt_q >= 8'(TIMEOUT - 1);
        be_d       = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
                     req_size_i == 2'b01 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
        wdata_d    = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
                     req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
        lb         = mem_rdata_i[{off_q, 3'b000} +: 8];
        lh         = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        rdata_d    = size_q == 2'b00 ? {{24{signed_q & lb[7]}}, lb} :
                     size_q == 2'b01 ? {{16{signed_q & lh[15]}}, lh} : mem_rdata_i;
        stall_o    = accept | state_q == REQ | state_q == WAIT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= '0;
            off_q          <= '0;
            resp_valid_o   <= 1'b0;
            resp_rdata_o   <= '0;
            misalign_err_o <= 1'b0;
            timeout_err_o  <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            mem_be_o       <= '0;
        end else begin
            resp_valid_o   <= 1'b0;
            timeout_err_o  <= 1'b0;
            misalign_err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    misalign_err_o <= req_valid_i & misaligned;
                    if (accept) begin
                        state_q     <= REQ;
                        cnt_q       <= '0;
                        we_q        <= req_we_i;
                        signed_q    <= req_signed_i;
                        size_q      <= req_size_i;
                        off_q       <= req_addr_i[1:0];
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= req_we_i;
                        mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                        mem_be_o    <= be_d;
                        mem_wdata_o <= wdata_d;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= we_q ? DONE : WAIT;
                        resp_valid_o <= we_q;
                    end else if (tmo) begin
                        mem_req_o     <= 1'b0;
                        state_q       <= DONE;
                        resp_valid_o  <= 1'b1;
                        timeout_err_o <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_rvalid_i) begin
                        state_q      <= DONE;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= rdata_d;
                    end else if (tmo) begin
                        state_q       <= DONE;
                        resp_valid_o  <= 1'b1;
                        timeout_err_o <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    resp_rdata_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed load/store sequence with a response scoreboard, TIMEOUT=8.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic        stall, resp_valid, misalign_err, timeout_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          checks = 0, errors = 0;

    typedef struct { logic [31:0] rdata; logic tmo; } resp_t;
    resp_t sb[$];

    dmem_access_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .stall_o(stall), .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata), .misalign_err_o(misalign_err), .timeout_err_o(timeout_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({stall, resp_valid, misalign_err, timeout_err, mem_req, mem_we, mem_be}), 0);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    // gd: cycles of gnt delay after the first REQ cycle; rvd: cycles from gnt to rvalid
    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int gd, input int rvd, input logic [31:0] e_rd, input logic e_to,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input int e_stall, input int e_req);
        int    stl, reqc;
        bit    done;
        resp_t e;
        sb.push_back('{e_rd, e_to});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; mem_rdata = rd;
        #1;
        chk({tag, "_accept_stall"}, 32'(stall), 1);
        stl = 1; reqc = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            mem_gnt = (k == gd + 1);
            mem_rvalid = (k == gd + 1 + rvd);
            #1;
            stl += int'(stall);
            if (mem_req) begin
                reqc++;
                chk({tag, "_maddr"}, mem_addr, e_addr);
                chk({tag, "_be"}, 32'(mem_be), 32'(e_be));
                chk({tag, "_mwdata"}, mem_wdata, e_wd);
                chk({tag, "_mwe"}, 32'(mem_we), 32'(we));
            end
            if (resp_valid) begin
                if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
                else begin
                    e = sb.pop_front();
                    chk({tag, "_rdata"}, resp_rdata, e.rdata);
                    chk({tag, "_tmo"}, 32'(timeout_err), 32'(e.tmo));
                end
                chk({tag, "_done_cycle"}, k, e_stall);
                chk({tag, "_stall_cycles"}, stl, e_stall);
                chk({tag, "_req_cycles"}, reqc, e_req);
                req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
                done = 1;
            end
        end
        if (!done) chk({tag, "_no_resp"}, 0, 1);
    endtask

    initial begin
        #2;
        chk_idle_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        txn("lb",  0, 2'b00, 1, 32'h103, 0, 32'h80FF1234, 0, 1, 32'hFFFFFF80, 0, 32'h100, 4'b1000, 0, 3, 1);
        txn("lbu", 0, 2'b00, 0, 32'h103, 0, 32'h80FF1234, 0, 1, 32'h00000080, 0, 32'h100, 4'b1000, 0, 3, 1);
        txn("sh",  1, 2'b01, 0, 32'h202, 32'h1234BEEF, 0, 0, 1, 0, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 2, 1);
        txn("sb",  1, 2'b00, 0, 32'h001, 32'h000000A5, 0, 0, 1, 0, 0, 32'h000, 4'b0010, 32'hA5A5A5A5, 2, 1);
        txn("lh",  0, 2'b01, 1, 32'h202, 0, 32'h80015678, 0, 1, 32'hFFFF8001, 0, 32'h200, 4'b1100, 0, 3, 1);
        txn("lhu", 0, 2'b01, 0, 32'h200, 0, 32'h8001F00D, 0, 1, 32'h0000F00D, 0, 32'h200, 4'b0011, 0, 3, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h101;
        #1;
        chk("mis_stall", 32'(stall), 0);
        chk("mis_req0", 32'(mem_req), 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mis_pulse", 32'(misalign_err), 1);
        chk("mis_req1", 32'(mem_req), 0);
        @(negedge clk); #1;
        chk("mis_pulse_end", 32'(misalign_err), 0);
        txn("lw_slow", 0, 2'b10, 0, 32'h300, 0, 32'hCAFEF00D, 3, 2, 32'hCAFEF00D, 0, 32'h300, 4'b1111, 0, 7, 4);
        txn("lw_tmo",  0, 2'b10, 0, 32'h400, 0, 32'h55AA55AA, 99, 99, 0, 1, 32'h400, 4'b1111, 0, 9, 8);
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        chk("late_rv_resp0", 32'(resp_valid), 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late_rv_resp1", 32'(resp_valid), 0);
        @(negedge clk);
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h500; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall), 1);
        chk("rst_wait_req", 32'(mem_req), 0);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk_idle_zero("async_rst");
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("stray_rv_resp", 32'(resp_valid), 0);
        chk("stray_rv_stall", 32'(stall), 0);
        txn("lw_after_rst", 0, 2'b10, 0, 32'h40, 0, 32'h11223344, 0, 1, 32'h11223344, 0, 32'h40, 4'b1111, 0, 3, 1);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's decoded memory controls and a request/grant data-memory bus.
- Takes access size, signedness and direction from the decoder, issues one aligned word request with byte enables, and stalls the core until completion.
- Returns sign- or zero-extended load data and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before abort; legal range 2..255 (8-bit counter).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core presents a load/store; must be held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  1=sign-extend load, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  core must hold the current instruction
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  extended load data; 0 for stores/errors
- misalign_err  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse, coincident with resp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  bus accepts request this cycle
- mem_rvalid  in  1  load data valid; earliest the cycle after gnt
- mem_rdata  in  32  load word

Behaviour:
- Reset: state IDLE, counter 0, every output 0 (mem_addr/wdata/be included). rst_n low mid-operation drops mem_req immediately. A stray mem_rvalid arriving after reset is ignored.
- Misaligned: size=11; or half with addr[0]=1; or word with addr[1:0]!=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid and aligned: register we/size/signed/addr[1:0]; build be/wdata/addr; go to REQ. stall=1 combinationally in this cycle.
- IDLE, req_valid and misaligned: stay in IDLE; misalign_err=1 next cycle, one cycle only; no mem_req; stall=0. The core owns the trap.
- REQ: mem_req=1, outputs held stable. On mem_gnt: a store goes to DONE, a load goes to WAIT. mem_rvalid is ignored in REQ.
- WAIT: mem_req=0. On mem_rvalid, capture the extended data into resp_rdata and go to DONE.
- DONE: resp_valid=1, stall=0; unconditionally return to IDLE. req_valid is ignored during DONE because the core advances at the end of this cycle.
- stall = (state==IDLE & req_valid & aligned) | state==REQ | state==WAIT.
- Timeout: the counter clears on entry to REQ and increments each REQ/WAIT cycle. When it reaches TIMEOUT, go to DONE with timeout_err=1 and resp_rdata=0, and drop mem_req. A later rvalid is ignored. If gnt/rvalid coincides with the timeout, the normal completion wins.
- Byte enables: byte = 0001<<a; half = 0011<<a; word = 1111, where a = addr[1:0].
- mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: byte = mem_rdata[8a+7:8a]; half = mem_rdata[16a1+15:16a1], where a1 = addr[1]; word passes through. Extend to 32 bits per req_signed.
- Latency with zero-wait bus (gnt in first REQ cycle, rvalid the next cycle):
  - Load: accept T, REQ T+1, WAIT T+2, DONE T+3; stall high T..T+2.
  - Store: accept T, REQ T+1, DONE T+2; stall high T..T+1.
- Each added gnt/rvalid wait cycle adds one stall cycle.
- Back-to-back: a new request can be accepted the cycle after DONE.
- Registered outputs: resp_*, the error pulses and mem_*. stall is combinational.

Test Plan:
- LB, addr 0x103, rdata 0x80FF1234, zero-wait bus:
  - mem_addr 0x100, be 1000.
  - resp_rdata 0xFFFFFF80 at T+3; stall high exactly 3 cycles.
  - Repeat as LBU: resp_rdata 0x00000080.
- SH, addr 0x202, wdata 0x1234BEEF:
  - mem_addr 0x200, be 1100, mem_wdata 0xBEEFBEEF, mem_we=1.
  - resp_valid at T+2, resp_rdata 0.
- LH signed at 0x202 (rdata 0x8001xxxx) -> 0xFFFF8001; LW at 0x101 -> misalign_err pulse at T+1, mem_req never high, stall 0.
- Gnt delayed 3 cycles, rvalid 2 cycles after gnt:
  - mem_req/addr held stable through all REQ cycles.
  - stall high 1+4+2 cycles; resp_valid lands exactly in DONE.
- TIMEOUT=8, gnt never asserted: mem_req high 8 cycles; then resp_valid=1 and timeout_err=1 together with resp_rdata 0. A late rvalid produces no second resp_valid.
- rst_n pulsed low during WAIT: all outputs 0 asynchronously. A subsequent mem_rvalid is ignored. After release, a fresh LW at 0x40 completes normally.
